vga_frame_buffer: RTL

Double-buffered (ping-pong) frame store for the VGA path, succeeding the single-bank frame RAM. A pixel source fills the back bank through the write port while the VGA scan-out reads the front bank. The banks swap only on a frame-sync pulse and only after the back bank has been completely written, so the display never shows a torn frame. Memory depth, pixel width and counter width are parameters; range checking and drop detection are new.

---
 rtl/vga_frame_buffer_if.sv | 36 +++
 rtl/vga_frame_buffer.sv | 116 +++++++++++
 2 files changed

// File: rtl/vga_frame_buffer_if.sv
// Bus bundle for the ping-pong VGA frame store: pixel write port, scan-out
// read port, frame sync and writer/bank status.
interface vga_frame_buffer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 17,
  parameter int CNT_WIDTH  = 8
);
  logic                  en_i_fb;
  logic                  we_i_fb;
  logic [ADDR_WIDTH-1:0] wr_addr_i_fb;
  logic [DATA_WIDTH-1:0] wr_data_i_fb;
  logic                  re_i_fb;
  logic [ADDR_WIDTH-1:0] rd_addr_i_fb;
  logic                  frame_sync_i_fb;
  logic [DATA_WIDTH-1:0] rd_data_o_fb;
  logic                  rd_valid_o_fb;
  logic                  rd_frame_done_o_fb;
  logic                  wr_ready_o_fb;
  logic                  wr_frame_done_o_fb;
  logic                  swap_o_fb;
  logic                  front_bank_o_fb;
  logic [CNT_WIDTH-1:0]  frame_cnt_o_fb;
  logic                  err_o_fb;

  modport master (
    output en_i_fb, we_i_fb, wr_addr_i_fb, wr_data_i_fb, re_i_fb, rd_addr_i_fb, frame_sync_i_fb,
    input  rd_data_o_fb, rd_valid_o_fb, rd_frame_done_o_fb, wr_ready_o_fb, wr_frame_done_o_fb,
           swap_o_fb, front_bank_o_fb, frame_cnt_o_fb, err_o_fb
  );

  modport slave (
    input  en_i_fb, we_i_fb, wr_addr_i_fb, wr_data_i_fb, re_i_fb, rd_addr_i_fb, frame_sync_i_fb,
    output rd_data_o_fb, rd_valid_o_fb, rd_frame_done_o_fb, wr_ready_o_fb, wr_frame_done_o_fb,
           swap_o_fb, front_bank_o_fb, frame_cnt_o_fb, err_o_fb
  );
endinterface

// File: rtl/vga_frame_buffer.sv
// Double-buffered VGA frame store: the writer fills the back bank, scan-out reads
// the front bank, and banks swap on frame sync only once the back bank is full.
module vga_frame_buffer #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 17,
  parameter int FRAME_DEPTH = 76800,
  parameter int CNT_WIDTH   = 8
) (
  input  logic               clk_i_fb,
  input  logic               rstn_i_fb,
  vga_frame_buffer_if.slave  fb
);
  localparam int IDX_W = (FRAME_DEPTH > 1) ? $clog2(FRAME_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(FRAME_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_C  = ADDR_WIDTH'(FRAME_DEPTH - 1);

  typedef enum logic [0:0] {FILL = 1'b0, READY = 1'b1} wr_state_t;

  wr_state_t             state_r, state_nxt_s;
  logic [DATA_WIDTH-1:0] bank0_r [FRAME_DEPTH];
  logic [DATA_WIDTH-1:0] bank1_r [FRAME_DEPTH];
  logic [DATA_WIDTH-1:0] rd_word_s, rd_data_r;
  logic                  rd_valid_r, rd_done_r, swap_r, front_r, err_r;
  logic [CNT_WIDTH-1:0]  cnt_r;
  logic                  wr_ready_s, wr_done_s;
  logic                  wr_req_s, wr_in_rng_s, wr_acc_s, wr_last_s;
  logic                  rd_req_s, rd_in_rng_s, rd_acc_s;
  logic                  swap_s, err_set_s;
  logic [IDX_W-1:0]      wr_idx_s, rd_idx_s;

  assign wr_req_s    = fb.en_i_fb & fb.we_i_fb;
  assign wr_in_rng_s = {1'b0, fb.wr_addr_i_fb} < DEPTH_C;
  // Writes are only taken while filling, and never while reset is held.
  assign wr_acc_s    = rstn_i_fb & wr_req_s & wr_in_rng_s & (state_r == FILL);
  assign wr_last_s   = wr_acc_s & (fb.wr_addr_i_fb == LAST_C);
  assign rd_req_s    = fb.en_i_fb & fb.re_i_fb;
  assign rd_in_rng_s = {1'b0, fb.rd_addr_i_fb} < DEPTH_C;
  assign rd_acc_s    = rd_req_s & rd_in_rng_s;
  assign swap_s      = (state_r == READY) & fb.frame_sync_i_fb;
  assign err_set_s   = (wr_req_s & (~wr_in_rng_s | (state_r == READY))) | (rd_req_s & ~rd_in_rng_s);
  assign wr_idx_s    = fb.wr_addr_i_fb[IDX_W-1:0];
  assign rd_idx_s    = fb.rd_addr_i_fb[IDX_W-1:0];

  // Writer state register.
  always_ff @(posedge clk_i_fb) begin
    if (!rstn_i_fb) state_r <= FILL;
    else            state_r <= state_nxt_s;
  end

  // Writer next state: a sync arriving with the last write is not taken.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      FILL:    if (wr_last_s) state_nxt_s = READY; else state_nxt_s = FILL;
      READY:   if (fb.frame_sync_i_fb) state_nxt_s = FILL; else state_nxt_s = READY;
      default: state_nxt_s = FILL;
    endcase
  end

  // Writer status decode from the state register.
  always_comb begin
    wr_ready_s = 1'b1;
    wr_done_s  = 1'b0;
    case (state_r)
      FILL:    begin wr_ready_s = 1'b1; wr_done_s = 1'b0; end
      READY:   begin wr_ready_s = 1'b0; wr_done_s = 1'b1; end
      default: begin wr_ready_s = 1'b1; wr_done_s = 1'b0; end
    endcase
  end

  // Back-bank write port; bank contents are intentionally not reset.
  always_ff @(posedge clk_i_fb) begin
    if (wr_acc_s) begin
      if (front_r) bank0_r[wr_idx_s] <= fb.wr_data_i_fb;
      else         bank1_r[wr_idx_s] <= fb.wr_data_i_fb;
    end
  end

  // Front-bank read mux.
  always_comb begin
    rd_word_s = {DATA_WIDTH{1'b0}};
    if (front_r) rd_word_s = bank1_r[rd_idx_s];
    else         rd_word_s = bank0_r[rd_idx_s];
  end

  // Registered read port, bank select and status outputs.
  always_ff @(posedge clk_i_fb) begin
    if (!rstn_i_fb) begin
      rd_data_r  <= {DATA_WIDTH{1'b0}};
      rd_valid_r <= 1'b0;
      rd_done_r  <= 1'b0;
      swap_r     <= 1'b0;
      front_r    <= 1'b0;
      cnt_r      <= {CNT_WIDTH{1'b0}};
      err_r      <= 1'b0;
    end else begin
      rd_data_r  <= rd_acc_s ? rd_word_s : {DATA_WIDTH{1'b0}};
      rd_valid_r <= rd_acc_s;
      rd_done_r  <= rd_acc_s & (fb.rd_addr_i_fb == LAST_C);
      swap_r     <= swap_s;
      front_r    <= front_r ^ swap_s;
      cnt_r      <= swap_s ? cnt_r + CNT_WIDTH'(1) : cnt_r;
      err_r      <= err_r | err_set_s;
    end
  end

  assign fb.rd_data_o_fb       = rd_data_r;
  assign fb.rd_valid_o_fb      = rd_valid_r;
  assign fb.rd_frame_done_o_fb = rd_done_r;
  assign fb.wr_ready_o_fb      = wr_ready_s;
  assign fb.wr_frame_done_o_fb = wr_done_s;
  assign fb.swap_o_fb          = swap_r;
  assign fb.front_bank_o_fb    = front_r;
  assign fb.frame_cnt_o_fb     = cnt_r;
  assign fb.err_o_fb           = err_r;
endmodule
